// File: rtl/axis_pkt_loopback_buf_pkg.sv
// Shared definitions for the AXIS packet loopback buffer: TUSER field positions,
// beat layout, FSM encodings and the TUSER rewrite helper.
package axis_pkt_loopback_buf_pkg;

    localparam int USER_W = 128;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;
    localparam int LEN_W  = 16;
    localparam int BEAT_W = DATA_W + STRB_W + 1;

    localparam int TUSER_LEN_LSB = 0;
    localparam int TUSER_LEN_MSB = 15;
    localparam int TUSER_SPT_LSB = 16;
    localparam int TUSER_SPT_MSB = 23;
    localparam int TUSER_DPT_LSB = 24;
    localparam int TUSER_DPT_MSB = 31;

    typedef enum logic [1:0] {
        IN_IDLE = 2'd0,
        IN_PKT  = 2'd1,
        IN_DROP = 2'd2
    } in_state_t;

    typedef enum logic {
        OUT_IDLE = 1'b0,
        OUT_SEND = 1'b1
    } out_state_t;

    function automatic logic [2:0] strb_bytes(input logic [STRB_W-1:0] s);
        return {2'b00, s[0]} + {2'b00, s[1]} + {2'b00, s[2]} + {2'b00, s[3]};
    endfunction

    // Egress TUSER: counted length in the low half-word, source and destination ports swapped.
    function automatic logic [USER_W-1:0] rewrite_tuser(input logic [USER_W-1:0] u,
                                                        input logic [LEN_W-1:0]  len);
        logic [USER_W-1:0] r;
        r = u;
        r[TUSER_LEN_MSB:TUSER_LEN_LSB] = len;
        r[TUSER_SPT_MSB:TUSER_SPT_LSB] = u[TUSER_DPT_MSB:TUSER_DPT_LSB];
        r[TUSER_DPT_MSB:TUSER_DPT_LSB] = u[TUSER_SPT_MSB:TUSER_SPT_LSB];
        return r;
    endfunction

endpackage

// File: rtl/axis_pkt_ram.sv
// Simple dual-port beat RAM with one write port and a registered read port.
// The read register clears on reset so the egress data bus reads 0 out of reset.
module axis_pkt_ram #(
    parameter int DEPTH = 512,
    parameter int W     = 37
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/axis_pkt_loopback_buf.sv
// Store-and-forward AXIS packet buffer: holds whole packets, rewrites TUSER (length, port swap)
// and drops any packet that overruns the data FIFO so ingress can never deadlock.
module axis_pkt_loopback_buf
    import axis_pkt_loopback_buf_pkg::*;
#(
    parameter int DATA_DEPTH = 512,
    parameter int META_DEPTH = 16
) (
    input  logic                        ACLK,
    input  logic                        ARESETN,
    input  logic [DATA_W-1:0]           S_AXIS_DAT_TDATA,
    input  logic [STRB_W-1:0]           S_AXIS_DAT_TSTRB,
    input  logic [USER_W-1:0]           S_AXIS_DAT_TUSER,
    input  logic                        S_AXIS_DAT_TLAST,
    input  logic                        S_AXIS_DAT_TVALID,
    output logic                        S_AXIS_DAT_TREADY,
    output logic [DATA_W-1:0]           M_AXIS_DAT_TDATA,
    output logic [STRB_W-1:0]           M_AXIS_DAT_TSTRB,
    output logic [USER_W-1:0]           M_AXIS_DAT_TUSER,
    output logic                        M_AXIS_DAT_TLAST,
    output logic                        M_AXIS_DAT_TVALID,
    input  logic                        M_AXIS_DAT_TREADY,
    output logic [31:0]                 STAT_PKTS,
    output logic [31:0]                 STAT_DROPS,
    output logic [$clog2(DATA_DEPTH):0] STAT_LEVEL,
    output in_state_t                   DBG_IN_STATE,
    output out_state_t                  DBG_OUT_STATE
);

    // Both ports use AXIS valid/ready: a beat transfers on the rising ACLK edge where
    // TVALID and TREADY are both high; a source holds its beat stable until then.

    localparam int AW  = $clog2(DATA_DEPTH);
    localparam int MAW = $clog2(META_DEPTH);
    localparam logic [AW:0]  DEPTH_L = (AW+1)'(DATA_DEPTH);
    localparam logic [MAW:0] MDEPTH_L = (MAW+1)'(META_DEPTH);

    in_state_t         in_state;
    out_state_t        out_state;
    logic [AW:0]       wr_ptr;
    logic [AW:0]       wr_commit;
    logic [AW:0]       rd_ptr;
    logic [AW:0]       rd_next;
    logic [LEN_W-1:0]  len_r;
    logic [LEN_W-1:0]  len_next;
    logic [USER_W-1:0] user_r;
    logic [USER_W-1:0] user_cur;
    logic              rdy_en;

    logic [USER_W-1:0] meta_mem [META_DEPTH];
    logic [MAW:0]      meta_wr;
    logic [MAW:0]      meta_rd;
    logic              meta_full;
    logic              meta_empty;
    logic              meta_push;

    logic              fifo_full;
    logic              s_hs;
    logic              m_hs;
    logic              ram_we;
    logic [BEAT_W-1:0] ram_rdata;
    logic              m_valid_r;
    logic [USER_W-1:0] m_user_r;

    assign meta_full  = (meta_wr - meta_rd) == MDEPTH_L;
    assign meta_empty = (meta_wr == meta_rd);
    assign fifo_full  = (wr_ptr - rd_ptr) == DEPTH_L;

    assign S_AXIS_DAT_TREADY = rdy_en && ((in_state == IN_DROP) || !meta_full);
    assign s_hs = S_AXIS_DAT_TVALID && S_AXIS_DAT_TREADY;
    assign m_hs = m_valid_r && M_AXIS_DAT_TREADY;

    assign user_cur  = (in_state == IN_IDLE) ? S_AXIS_DAT_TUSER : user_r;
    assign len_next  = ((in_state == IN_IDLE) ? '0 : len_r) + LEN_W'(strb_bytes(S_AXIS_DAT_TSTRB));
    assign ram_we    = s_hs && (in_state != IN_DROP) && !fifo_full;
    assign meta_push = ram_we && S_AXIS_DAT_TLAST;

    // Reading one beat ahead on a handshake keeps the egress stream bubble-free.
    assign rd_next = m_hs ? rd_ptr + 1'b1 : rd_ptr;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            in_state   <= IN_IDLE;
            wr_ptr     <= '0;
            wr_commit  <= '0;
            len_r      <= '0;
            user_r     <= '0;
            rdy_en     <= 1'b0;
            meta_wr    <= '0;
            STAT_PKTS  <= '0;
            STAT_DROPS <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (meta_push) begin
                meta_wr <= meta_wr + 1'b1;
            end
            if (s_hs) begin
                case (in_state)
                    IN_IDLE, IN_PKT: begin
                        if (fifo_full) begin
                            // Rewind to the last committed packet; its beats stay intact.
                            wr_ptr <= wr_commit;
                            if (S_AXIS_DAT_TLAST) begin
                                STAT_DROPS <= STAT_DROPS + 1'b1;
                                in_state   <= IN_IDLE;
                            end else begin
                                in_state   <= IN_DROP;
                            end
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                            len_r  <= len_next;
                            user_r <= user_cur;
                            if (S_AXIS_DAT_TLAST) begin
                                wr_commit <= wr_ptr + 1'b1;
                                STAT_PKTS <= STAT_PKTS + 1'b1;
                                in_state  <= IN_IDLE;
                            end else begin
                                in_state  <= IN_PKT;
                            end
                        end
                    end
                    IN_DROP: begin
                        if (S_AXIS_DAT_TLAST) begin
                            STAT_DROPS <= STAT_DROPS + 1'b1;
                            in_state   <= IN_IDLE;
                        end
                    end
                    default: in_state <= IN_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (meta_push) begin
            meta_mem[meta_wr[MAW-1:0]] <= rewrite_tuser(user_cur, len_next);
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            out_state <= OUT_IDLE;
            m_valid_r <= 1'b0;
            m_user_r  <= '0;
            rd_ptr    <= '0;
            meta_rd   <= '0;
        end else begin
            case (out_state)
                OUT_IDLE: begin
                    if (!meta_empty) begin
                        m_user_r  <= meta_mem[meta_rd[MAW-1:0]];
                        meta_rd   <= meta_rd + 1'b1;
                        m_valid_r <= 1'b1;
                        out_state <= OUT_SEND;
                    end
                end
                OUT_SEND: begin
                    if (m_hs) begin
                        rd_ptr <= rd_ptr + 1'b1;
                        if (ram_rdata[0]) begin
                            m_valid_r <= 1'b0;
                            out_state <= OUT_IDLE;
                        end
                    end
                end
                default: out_state <= OUT_IDLE;
            endcase
        end
    end

    axis_pkt_ram #(
        .DEPTH (DATA_DEPTH),
        .W     (BEAT_W)
    ) u_ram (
        .clk   (ACLK),
        .rst_n (ARESETN),
        .we    (ram_we),
        .waddr (wr_ptr[AW-1:0]),
        .wdata ({S_AXIS_DAT_TDATA, S_AXIS_DAT_TSTRB, S_AXIS_DAT_TLAST}),
        .raddr (rd_next[AW-1:0]),
        .rdata (ram_rdata)
    );

    assign M_AXIS_DAT_TDATA  = ram_rdata[BEAT_W-1:STRB_W+1];
    assign M_AXIS_DAT_TSTRB  = ram_rdata[STRB_W:1];
    assign M_AXIS_DAT_TLAST  = ram_rdata[0];
    assign M_AXIS_DAT_TUSER  = m_user_r;
    assign M_AXIS_DAT_TVALID = m_valid_r;
    assign STAT_LEVEL        = wr_commit - rd_ptr;
    assign DBG_IN_STATE      = in_state;
    assign DBG_OUT_STATE     = out_state;

endmodule

// File: tb/tb_axis_pkt_loopback_buf.sv
// Bench for axis_pkt_loopback_buf: directed cases plus random packets against a
// queue-based packet model of the buffer's rewrite and drop rules.
`timescale 1ns/1ps
module tb_axis_pkt_loopback_buf;
    import axis_pkt_loopback_buf_pkg::*;

    localparam int DD = 16;
    localparam int MD = 2;
    localparam int W  = 165;
    localparam int LW = $clog2(DD) + 1;

    logic              ACLK = 1'b0;
    logic              ARESETN = 1'b0;
    logic [31:0]       S_TDATA = '0;
    logic [3:0]        S_TSTRB = '0;
    logic [127:0]      S_TUSER = '0;
    logic              S_TLAST = 1'b0;
    logic              S_TVALID = 1'b0;
    logic              S_TREADY;
    logic [31:0]       M_TDATA;
    logic [3:0]        M_TSTRB;
    logic [127:0]      M_TUSER;
    logic              M_TLAST;
    logic              M_TVALID;
    logic              M_TREADY = 1'b0;
    logic [31:0]       STAT_PKTS;
    logic [31:0]       STAT_DROPS;
    logic [LW-1:0]     STAT_LEVEL;
    in_state_t         dbg_in;
    out_state_t        dbg_out;

    int                n_checks = 0;
    int                n_fail = 0;
    int                cyc = 0;
    logic [W-1:0]      exp_q[$];
    int                n_commit_beats = 0;
    int                n_rcv_beats = 0;
    bit                throttle = 1'b0;
    bit                rand_ready = 1'b0;
    logic              m_ready_fix = 1'b0;
    int                last_in_cyc = 0;
    int                first_valid_cyc = 0;
    logic              prev_m_valid = 1'b0;
    logic              held_valid = 1'b0;
    logic [W-1:0]      held_beat = '0;
    logic [31:0]       pkt_data [64];
    logic [3:0]        pkt_strb [64];

    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc++;

    always @(posedge ACLK) begin
        #1;
        M_TREADY = rand_ready ? 1'($urandom_range(0, 1)) : m_ready_fix;
    end

    axis_pkt_loopback_buf #(
        .DATA_DEPTH (DD),
        .META_DEPTH (MD)
    ) dut (
        .ACLK              (ACLK),
        .ARESETN           (ARESETN),
        .S_AXIS_DAT_TDATA  (S_TDATA),
        .S_AXIS_DAT_TSTRB  (S_TSTRB),
        .S_AXIS_DAT_TUSER  (S_TUSER),
        .S_AXIS_DAT_TLAST  (S_TLAST),
        .S_AXIS_DAT_TVALID (S_TVALID),
        .S_AXIS_DAT_TREADY (S_TREADY),
        .M_AXIS_DAT_TDATA  (M_TDATA),
        .M_AXIS_DAT_TSTRB  (M_TSTRB),
        .M_AXIS_DAT_TUSER  (M_TUSER),
        .M_AXIS_DAT_TLAST  (M_TLAST),
        .M_AXIS_DAT_TVALID (M_TVALID),
        .M_AXIS_DAT_TREADY (M_TREADY),
        .STAT_PKTS         (STAT_PKTS),
        .STAT_DROPS        (STAT_DROPS),
        .STAT_LEVEL        (STAT_LEVEL),
        .DBG_IN_STATE      (dbg_in),
        .DBG_OUT_STATE     (dbg_out)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Egress scoreboard: every handshaked beat must match the head of the expected queue,
    // and a stalled beat must be repeated unchanged on the next cycle.
    always @(negedge ACLK) begin
        logic [W-1:0] cur;
        logic [W-1:0] exp;
        if (!ARESETN) begin
            held_valid   = 1'b0;
            prev_m_valid = 1'b0;
        end else begin
            cur = {M_TUSER, M_TLAST, M_TSTRB, M_TDATA};
            if (M_TVALID && !prev_m_valid) first_valid_cyc = cyc;
            prev_m_valid = M_TVALID;
            if (held_valid) begin
                check("stall_valid", W'(M_TVALID), W'(1));
                check("stall_stable", cur, held_beat);
            end
            if (M_TVALID && M_TREADY) begin
                exp = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
                check("egress_beat", cur, exp);
                n_rcv_beats++;
            end
            held_valid = M_TVALID && !M_TREADY;
            held_beat  = cur;
        end
    end

    task automatic send_beat(input logic [31:0] d, input logic [3:0] s, input logic [127:0] u,
                             input logic l, output int stalls);
        S_TDATA  = d;
        S_TSTRB  = s;
        S_TUSER  = u;
        S_TLAST  = l;
        S_TVALID = 1'b1;
        stalls   = 0;
        while (1) begin
            @(negedge ACLK);
            if (S_TREADY) break;
            stalls++;
            if (stalls > 3000) break;
        end
        if (!S_TREADY) check("s_tready_timeout", W'(S_TREADY), W'(1));
        if (S_TREADY && l) last_in_cyc = cyc;
        @(posedge ACLK);
        #1;
        S_TVALID = 1'b0;
        S_TLAST  = 1'b0;
    endtask

    // Sends pkt_data/pkt_strb[0..nb-1]; the model commits it unless it exceeds the FIFO.
    task automatic send_pkt(input int nb, input logic [127:0] u, output int stalls);
        int           st;
        int           len;
        int           waited;
        logic [127:0] uo;
        stalls = 0;
        len    = 0;
        if (throttle) begin
            waited = 0;
            while ((n_commit_beats - n_rcv_beats + nb > DD) && (waited < 5000)) begin
                @(negedge ACLK);
                waited++;
            end
            if (waited >= 5000) check("throttle_timeout", W'(n_commit_beats - n_rcv_beats), W'(DD - nb));
            @(posedge ACLK);
            #1;
        end
        for (int i = 0; i < nb; i++) begin
            send_beat(pkt_data[i], pkt_strb[i], u, (i == nb - 1), st);
            stalls += st;
            len += $countones(pkt_strb[i]);
        end
        if (nb <= DD) begin
            uo = {u[127:32], u[23:16], u[31:24], 16'(len)};
            for (int i = 0; i < nb; i++) begin
                exp_q.push_back({uo, (i == nb - 1), pkt_strb[i], pkt_data[i]});
            end
            n_commit_beats += nb;
        end
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (n < budget) begin
            @(negedge ACLK);
            if (exp_q.size() == 0 && !M_TVALID) break;
            n++;
        end
        if (n >= budget) check("drain_timeout", W'(exp_q.size()), W'(0));
        @(posedge ACLK);
        #1;
    endtask

    task automatic check_reset_outputs();
        check("rst_s_tready", W'(S_TREADY), W'(0));
        check("rst_m_tvalid", W'(M_TVALID), W'(0));
        check("rst_m_tdata", W'(M_TDATA), W'(0));
        check("rst_m_tstrb", W'(M_TSTRB), W'(0));
        check("rst_m_tuser", W'(M_TUSER), W'(0));
        check("rst_m_tlast", W'(M_TLAST), W'(0));
        check("rst_pkts", W'(STAT_PKTS), W'(0));
        check("rst_drops", W'(STAT_DROPS), W'(0));
        check("rst_level", W'(STAT_LEVEL), W'(0));
        check("rst_in_state", W'(dbg_in), W'(IN_IDLE));
        check("rst_out_state", W'(dbg_out), W'(OUT_IDLE));
    endtask

    task automatic clear_model();
        exp_q.delete();
        n_commit_beats = 0;
        n_rcv_beats    = 0;
    endtask

    task automatic reset_dut();
        ARESETN  = 1'b0;
        S_TVALID = 1'b0;
        S_TLAST  = 1'b0;
        clear_model();
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(posedge ACLK);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           st;
        int           nb;
        logic [127:0] u;

        // Reset state
        #2;
        check_reset_outputs();
        reset_dut();

        // Directed 3-beat packet: length 10, ports swapped, TVALID two cycles after TLAST
        m_ready_fix = 1'b1;
        repeat (2) @(posedge ACLK);
        #1;
        u = {$urandom(), $urandom(), $urandom(), 32'h0102_0000};
        for (int i = 0; i < 3; i++) pkt_data[i] = $urandom();
        pkt_strb[0] = 4'hF;
        pkt_strb[1] = 4'hF;
        pkt_strb[2] = 4'h3;
        send_pkt(3, u, st);
        wait_drain(200);
        check("t1_latency", W'(first_valid_cyc - last_in_cyc), W'(2));
        check("t1_tuser_low", W'(M_TUSER[31:0]), W'(32'h0201_000A));
        check("t1_tuser_high", W'(M_TUSER[127:32]), W'(u[127:32]));
        check("t1_pkts", W'(STAT_PKTS), W'(1));
        check("t1_level", W'(STAT_LEVEL), W'(0));

        // Oversize packet dropped without backpressure, next packet delivered
        reset_dut();
        m_ready_fix = 1'b1;
        for (int i = 0; i < 20; i++) begin
            pkt_data[i] = $urandom();
            pkt_strb[i] = 4'($urandom_range(0, 15));
        end
        send_pkt(20, {$urandom(), $urandom(), $urandom(), $urandom()}, st);
        check("t2_drop_stalls", W'(st), W'(0));
        for (int i = 0; i < 2; i++) pkt_data[i] = $urandom();
        pkt_strb[0] = 4'hF;
        pkt_strb[1] = 4'h1;
        send_pkt(2, {$urandom(), $urandom(), $urandom(), $urandom()}, st);
        check("t2_small_stalls", W'(st), W'(0));
        wait_drain(200);
        check("t2_drops", W'(STAT_DROPS), W'(1));
        check("t2_pkts", W'(STAT_PKTS), W'(1));
        // A packet exactly filling the empty FIFO is accepted
        for (int i = 0; i < DD; i++) begin
            pkt_data[i] = $urandom();
            pkt_strb[i] = 4'($urandom_range(0, 15));
        end
        send_pkt(DD, {$urandom(), $urandom(), $urandom(), $urandom()}, st);
        check("t2_full_stalls", W'(st), W'(0));
        wait_drain(200);
        check("t2_full_pkts", W'(STAT_PKTS), W'(2));
        check("t2_full_drops", W'(STAT_DROPS), W'(1));

        // Metadata FIFO backpressure with egress stalled
        reset_dut();
        m_ready_fix = 1'b0;
        repeat (2) @(posedge ACLK);
        #1;
        for (int p = 0; p < 3; p++) begin
            pkt_data[0] = $urandom();
            pkt_strb[0] = 4'($urandom_range(0, 15));
            send_pkt(1, {$urandom(), $urandom(), $urandom(), $urandom()}, st);
            check("t3_accept_stalls", W'(st), W'(0));
        end
        @(negedge ACLK);
        check("t3_tready_low", W'(S_TREADY), W'(0));
        check("t3_level", W'(STAT_LEVEL), W'(3));
        check("t3_pkts", W'(STAT_PKTS), W'(3));
        @(posedge ACLK);
        #1;
        m_ready_fix = 1'b1;
        wait_drain(200);
        check("t3_level_drained", W'(STAT_LEVEL), W'(0));

        // Random packets with random egress backpressure
        reset_dut();
        throttle   = 1'b1;
        rand_ready = 1'b1;
        for (int p = 0; p < 200; p++) begin
            nb = $urandom_range(1, 16);
            for (int i = 0; i < nb; i++) begin
                pkt_data[i] = $urandom();
                pkt_strb[i] = 4'($urandom_range(0, 15));
            end
            send_pkt(nb, {$urandom(), $urandom(), $urandom(), $urandom()}, st);
        end
        wait_drain(5000);
        rand_ready = 1'b0;
        throttle   = 1'b0;
        check("t4_queue_empty", W'(exp_q.size()), W'(0));
        check("t4_pkts", W'(STAT_PKTS), W'(200));
        check("t4_drops", W'(STAT_DROPS), W'(0));
        check("t4_level", W'(STAT_LEVEL), W'(0));

        // Reset while a packet waits on egress and another is half received
        reset_dut();
        m_ready_fix = 1'b0;
        repeat (2) @(posedge ACLK);
        #1;
        pkt_data[0] = $urandom();
        pkt_strb[0] = 4'hF;
        send_pkt(1, {$urandom(), $urandom(), $urandom(), $urandom()}, st);
        repeat (4) @(posedge ACLK);
        #1;
        check("t5_egress_waiting", W'(M_TVALID), W'(1));
        send_beat($urandom(), 4'hF, {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0, st);
        send_beat($urandom(), 4'hF, {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0, st);
        #2;
        ARESETN = 1'b0;
        #1;
        check_reset_outputs();
        clear_model();
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(posedge ACLK);
        #1;
        m_ready_fix = 1'b1;
        pkt_data[0] = $urandom();
        pkt_strb[0] = 4'h7;
        send_pkt(1, {$urandom(), $urandom(), $urandom(), $urandom()}, st);
        wait_drain(200);
        check("t5_pkts", W'(STAT_PKTS), W'(1));
        check("t5_drops", W'(STAT_DROPS), W'(0));
        check("t5_level", W'(STAT_LEVEL), W'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
